truth_table_eval: RTL

//  Registered, field-programmable N-input truth-table evaluator; successor to the fixed 3-input case-table gates.

---
 rtl/truth_table_pkg.sv | 21 ++
 rtl/tt_shift_loader.sv | 94 +++++++++
 rtl/truth_table_eval.sv | 114 +++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and sizing helpers for the programmable truth-table evaluator.
package truth_table_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FLUSH  = 2'd2,
      COMMIT = 2'd3
   } ld_state_e;

   localparam logic [7:0] RESET_TT_DEF = 8'hF2;

   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(1 << n) + 1;
   endfunction

endpackage

// File: rtl/tt_shift_loader.sv
// Serial LSB-first table loader with shadow register; emits a 1-cycle commit pulse.
// Latency: commit one cycle after the cfg_last bit; cfg_ready_o drops only in the COMMIT cycle.
module tt_shift_loader
   import truth_table_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_valid_i,
   input  logic                        cfg_bit_i,
   input  logic                        cfg_last_i,
   output logic                        cfg_ready_o,
   output logic                        cfg_err_o,
   output logic                        commit_o,
   output logic [tt_width(N_IN)-1:0]   shadow_o
);

   localparam int TT_W = tt_width(N_IN);
   localparam int CW   = cnt_width(N_IN);
   localparam logic [CW-1:0] CNT_FULL = CW'(TT_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(TT_W - 1);

   ld_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TT_W-1:0]   shadow_q, shadow_d;
   logic              err_q, err_d;
   logic              accept;

   assign accept = cfg_valid_i && (state_q != COMMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      err_d    = err_q;
      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               // A bit beyond TT_W is an overrun: drop it and swallow the rest of the frame.
               if (cnt_q == CNT_FULL) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = cfg_last_i ? IDLE : FLUSH;
               end else begin
                  shadow_d[cnt_q[N_IN-1:0]] = cfg_bit_i;
                  if (cfg_last_i) begin
                     cnt_d = '0;
                     if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                     end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                     end
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     state_d = LOAD;
                  end
               end
            end
         end
         FLUSH: begin
            if (accept && cfg_last_i) begin
               state_d = IDLE;
            end
         end
         COMMIT: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cfg_ready_o = (state_q != COMMIT);
   assign commit_o    = (state_q == COMMIT);
   assign cfg_err_o   = err_q;
   assign shadow_o    = shadow_q;

endmodule

// File: rtl/truth_table_eval.sv
// Registered programmable N-input truth-table evaluator; latency 1, eval never backpressures.
// Optional SETTLE_FILTER_EN: output follows a result only after SETTLE_CYC equal consecutive samples.
module truth_table_eval
   import truth_table_pkg::*;
#(
   parameter int                          N_IN       = 3,
   parameter logic [tt_width(N_IN)-1:0]   RESET_TT   = RESET_TT_DEF,
   parameter int                          SETTLE_CYC = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_IN-1:0]             in_vec,
   input  logic                        in_valid,
   output logic                        out,
   output logic                        out_valid,
   input  logic                        cfg_valid,
   input  logic                        cfg_bit,
   input  logic                        cfg_last,
   output logic                        cfg_ready,
   output logic                        cfg_err,
   output logic [tt_width(N_IN)-1:0]   tt_active
);

   localparam int TT_W = tt_width(N_IN);

   logic              commit;
   logic [TT_W-1:0]   shadow;
   logic [TT_W-1:0]   tt_active_q;
   logic              out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              raw;

   tt_shift_loader #(.N_IN(N_IN)) u_loader (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid_i (cfg_valid),
      .cfg_bit_i   (cfg_bit),
      .cfg_last_i  (cfg_last),
      .cfg_ready_o (cfg_ready),
      .cfg_err_o   (cfg_err),
      .commit_o    (commit),
      .shadow_o    (shadow)
   );

   // A sample taken in the COMMIT cycle still sees the old table.
   assign raw = tt_active_q[in_vec];

   always_ff @(posedge clk) begin
      if (reset) begin
         tt_active_q <= RESET_TT;
      end else if (commit) begin
         tt_active_q <= shadow;
      end
   end

`ifdef SETTLE_FILTER_EN
   localparam int RW = $clog2(SETTLE_CYC) + 1;
   localparam logic [RW-1:0] RUN_SAT = RW'(SETTLE_CYC);

   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic          run_val_q, run_val_d;

   always_comb begin
      run_cnt_d   = run_cnt_q;
      run_val_d   = run_val_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (commit) begin
         run_cnt_d = '0;
      end else if (in_valid) begin
         if (raw == run_val_q) begin
            run_cnt_d = (run_cnt_q >= RUN_SAT) ? RUN_SAT : run_cnt_q + 1'b1;
         end else begin
            run_val_d = raw;
            run_cnt_d = RW'(1);
         end
         if ((run_cnt_d >= RUN_SAT) && (raw != out_q)) begin
            out_d       = raw;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt_q <= '0;
         run_val_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         run_val_q <= run_val_d;
      end
   end
`else
   always_comb begin
      out_d       = in_valid ? raw : out_q;
      out_valid_d = in_valid;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign tt_active = tt_active_q;

endmodule
